muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for RV64M ops in the execute stage; replaces the constant-high execute stall signal with a real one.
- Accepts an op from the ID/EX register, drives a fixed-latency pipelined multiplier, and runs an internal iterative radix-2 divider.
- Holds the execute stage (ok_to_proceed low) until the result is ready, then keeps the result stable until the pipeline advances.

Parameters:
- XLEN, 64, datapath width.
- MUL_LAT, 3, multiplier pipeline latency in cycles; must be 1 or more.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  ID/EX entry is valid and is an M-extension op.
- req_op  in  4  op code. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW. Bit3 marks a word op.
- req_a  in  XLEN  operand A (ia).
- req_b  in  XLEN  operand B (ib).
- advance  in  1  pipeline-wide proceed (ok_to_proceed_overall).
- flush  in  1  JumpEn; kills the in-flight op.
- ok_to_proceed  out  1  execute stage may advance.
- result  out  XLEN  final result, valid while state is DONE.
- busy  out  1  state is neither IDLE nor DONE.

Behaviour:
- States: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE.
- Reset (async): state IDLE, result 0, counters 0, busy 0. Combinationally this gives ok_to_proceed = !req_valid.
- ok_to_proceed:
  - 1 when flush is high.
  - Otherwise 1 when state is DONE, or when state is IDLE and req_valid is 0.
  - 0 in every other case.
- IDLE, req_valid high, no flush:
  - Mul op: issue to mul_pipe, load counter with MUL_LAT-1, go to MUL_WAIT.
  - Div/rem op with divisor 0 (low 32 bits for W ops): go directly to DONE. Quotient = all ones; remainder = dividend (sign-extended for W).
  - Signed div/rem overflow (MIN / -1, MIN being the 64- or 32-bit minimum): go directly to DONE. Quotient = MIN (sign-extended); remainder = 0.
  - Other div/rem: latch |a|, |b| (unsigned ops take the raw value; W ops use the low 32 bits), the result signs, and the iteration count N = 64 (or 32 for W). Go to DIV_RUN.
- MUL_WAIT: decrement the counter. At 0, capture the mul_pipe output into result and go to DONE. For MUL_LAT=3, ok_to_proceed is low for cycles 0-2 and high in cycle 3.
- DIV_RUN: restoring division, one quotient bit per cycle. Shift {rem,quo} left by 1, subtract the divisor, restore if negative. After N iterations go to DIV_FIX.
- DIV_FIX: apply the sign to quotient or remainder (negate as needed), sign-extend bit 31 for W ops, write result, go to DONE.
- Divide latency: ok_to_proceed is low for N+2 cycles (66 for 64-bit, 34 for W).
- DONE: hold result stable.
  - advance high: go to IDLE at the next edge.
  - advance low: stay in DONE, result unchanged.
- Back-to-back ops: the next M-op presented after advance is accepted in IDLE the following cycle. No op is accepted from DONE.
- Word mul (MULW): low 32 bits of the product, sign-extended. MULH/MULHSU/MULHU return the upper XLEN bits of the 128-bit product.
- Operand changes during MUL_WAIT/DIV_RUN/DIV_FIX are ignored; operands are latched at acceptance.
- flush in any state: go to IDLE next edge and discard any partial result (result register unchanged). Priority: flush over advance over sequencing.
- req_valid dropping mid-operation without flush is a protocol error; the block completes the op anyway.
- rst mid-operation: immediate return to IDLE with all reset values.

Decomposition:
- Shared package:
  - mdop_t enum with the op encodings above.
  - muldiv_state_t enum.
  - Constants MD_WORD_BIT = 3 and DIV_ZERO_Q = all ones.
- One sub-module, mul_pipe:
  - Signed/unsigned 65x65 multiply, MUL_LAT register stages.
  - Inputs a, b, a_signed, b_signed, word; output 128-bit product.
- The divider stays inside muldiv_seq.

Test Plan:
- MUL, a=7, b=-3, MUL_LAT=3, advance=1 -> ok_to_proceed low 3 cycles; then result = 0xFFFFFFFFFFFFFFEB in DONE; IDLE next cycle.
- DIV, a=-20, b=3 -> ok low 66 cycles, result = -6. REM on the same operands -> result = -2. DIVUW, a=0x1_00000064, b=10 -> ok low 34 cycles, result = 10.
- DIVU, b=0 -> DONE after 1 cycle, result = 0xFFFFFFFFFFFFFFFF. REMW, a=0x80000000, b=-1 -> DONE after 1 cycle, result = 0.
- MULHU, a=b=0xFFFFFFFFFFFFFFFF, advance held low 5 extra cycles -> result = 0xFFFFFFFFFFFFFFFE, stable and ok_to_proceed high throughout the hold.
- DIV started, flush at iteration 10 -> IDLE next cycle, ok_to_proceed=1. A following MUL 3*4 gives 12.
- rst pulsed during DIV_RUN -> IDLE, busy=0, result=0 immediately (async). Back-to-back MUL then DIVU accepted in consecutive IDLE cycles, both results correct.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op encodings, sequencer states and constants for the
//               RV64M multi-cycle multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd12,
        OP_DIVUW  = 4'd13,
        OP_REMW   = 4'd14,
        OP_REMUW  = 4'd15
    } mdop_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_WAIT = 3'd1,
        ST_DIV_RUN  = 3'd2,
        ST_DIV_FIX  = 3'd3,
        ST_DONE     = 3'd4
    } muldiv_state_t;

    localparam int          MD_WORD_BIT = 3;
    localparam logic [63:0] DIV_ZERO_Q  = '1;

    // Bit 2 separates the divide/remainder group from the multiplies.
    function automatic logic is_div_op(input logic [3:0] op);
        return op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mul_pipe
// Description : Signed/unsigned 65x65 multiplier with a register pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_pipe #(
    parameter int XLEN = 64,
    parameter int LAT  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic                a_signed,
    input  logic                b_signed,
    input  logic                word,
    output logic [2*XLEN-1:0]   product
);
    // The consumer's result register supplies the last stage of latency.
    localparam int STAGES = (LAT > 1) ? LAT - 1 : 1;

    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_full;
    logic [2*XLEN-1:0] w_prod;
    logic [STAGES-1:0][2*XLEN-1:0] r_stage;

    // Extending to 2*XLEN makes a plain modular product equal the signed one.
    assign w_a_ext = {{XLEN{a_signed & a[XLEN-1]}}, a};
    assign w_b_ext = {{XLEN{b_signed & b[XLEN-1]}}, b};
    assign w_full  = w_a_ext * w_b_ext;
    assign w_prod  = word ? {{(2*XLEN-32){w_full[31]}}, w_full[31:0]} : w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= w_prod;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign product = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Execute-stage sequencer for RV64M ops: pipelined multiply,
//               iterative radix-2 restoring divide, real stall generation.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            advance,
    input  logic            flush,
    output logic            ok_to_proceed,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam logic [XLEN-1:0] c_xlen_min = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_word_min = {{(XLEN-32){1'b1}}, 32'h8000_0000};

    muldiv_state_t r_state, w_next;
    logic [6:0]      r_cnt;
    logic [XLEN-1:0] r_result, r_rem, r_quo, r_dvs;
    logic            r_neg, r_is_rem, r_word, r_mul_hi;

    mdop_t           w_op;
    logic            w_word, w_is_div, w_unsigned, w_rem, w_a_neg, w_b_neg;
    logic            w_b_zero, w_ovf, w_a_signed, w_b_signed;
    logic [31:0]     w_a32_abs, w_b32_abs;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_sext_a, w_special;
    logic [XLEN:0]   w_shift, w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_fix_val, w_fix_neg, w_fix_res, w_mul_res;
    logic [2*XLEN-1:0] w_prod;

    // Operand decode for the op currently presented in IDLE.
    assign w_op       = mdop_t'(req_op);
    assign w_word     = req_op[MD_WORD_BIT];
    assign w_is_div   = is_div_op(req_op);
    assign w_unsigned = req_op[0];
    assign w_rem      = req_op[1];
    assign w_a_neg    = !w_unsigned && (w_word ? req_a[31] : req_a[XLEN-1]);
    assign w_b_neg    = !w_unsigned && (w_word ? req_b[31] : req_b[XLEN-1]);
    assign w_b_zero   = w_word ? (req_b[31:0] == 32'd0) : (req_b == '0);
    assign w_ovf      = !w_unsigned
                        && (w_word ? (req_a[31:0] == 32'h8000_0000) : (req_a == c_xlen_min))
                        && (w_word ? (&req_b[31:0]) : (&req_b));
    assign w_a32_abs  = w_a_neg ? -req_a[31:0] : req_a[31:0];
    assign w_b32_abs  = w_b_neg ? -req_b[31:0] : req_b[31:0];
    // Word dividends sit in the top half so 32 shifts consume exactly them.
    assign w_abs_a    = w_word ? {w_a32_abs, {(XLEN-32){1'b0}}} : (w_a_neg ? -req_a : req_a);
    assign w_abs_b    = w_word ? {{(XLEN-32){1'b0}}, w_b32_abs} : (w_b_neg ? -req_b : req_b);
    assign w_sext_a   = w_word ? {{(XLEN-32){req_a[31]}}, req_a[31:0]} : req_a;
    assign w_special  = w_b_zero ? (w_rem ? w_sext_a : DIV_ZERO_Q[XLEN-1:0])
                                 : (w_rem ? '0 : (w_word ? c_word_min : c_xlen_min));
    assign w_a_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU);
    assign w_b_signed = (w_op == OP_MULH);

    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_qbit    = !w_diff[XLEN];

    assign w_fix_val = r_is_rem ? r_rem : r_quo;
    assign w_fix_neg = r_neg ? -w_fix_val : w_fix_val;
    assign w_fix_res = r_word ? {{(XLEN-32){w_fix_neg[31]}}, w_fix_neg[31:0]} : w_fix_neg;
    assign w_mul_res = r_mul_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

    mul_pipe #(
        .XLEN (XLEN),
        .LAT  (MUL_LAT)
    ) u_mul_pipe (
        .clk      (clk),
        .rst      (rst),
        .a        (req_a),
        .b        (req_b),
        .a_signed (w_a_signed),
        .b_signed (w_b_signed),
        .word     (w_word),
        .product  (w_prod)
    );

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (!w_is_div)               w_next = ST_MUL_WAIT;
                        else if (w_b_zero || w_ovf)  w_next = ST_DONE;
                        else                         w_next = ST_DIV_RUN;
                    end
                end
                ST_MUL_WAIT: if (r_cnt <= 7'd1) w_next = ST_DONE;
                ST_DIV_RUN:  if (r_cnt == 7'd1) w_next = ST_DIV_FIX;
                ST_DIV_FIX:  w_next = ST_DONE;
                ST_DONE:     if (advance) w_next = ST_IDLE;
                default:     w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_neg    <= 1'b0;
            r_is_rem <= 1'b0;
            r_word   <= 1'b0;
            r_mul_hi <= 1'b0;
        end else begin
            r_state <= w_next;
            if (!flush) begin
                case (r_state)
                    ST_IDLE: begin
                        if (req_valid) begin
                            r_word   <= w_word;
                            r_is_rem <= w_rem;
                            r_neg    <= w_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
                            r_mul_hi <= !w_word && (req_op[1:0] != 2'd0);
                            if (!w_is_div) begin
                                r_cnt <= 7'(MUL_LAT - 1);
                            end else if (w_b_zero || w_ovf) begin
                                r_result <= w_special;
                            end else begin
                                r_rem <= '0;
                                r_quo <= w_abs_a;
                                r_dvs <= w_abs_b;
                                r_cnt <= w_word ? 7'd32 : 7'(XLEN);
                            end
                        end
                    end
                    ST_MUL_WAIT: begin
                        r_cnt <= r_cnt - 7'd1;
                        if (r_cnt <= 7'd1) r_result <= w_mul_res;
                    end
                    ST_DIV_RUN: begin
                        r_rem <= w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], w_qbit};
                        r_cnt <= r_cnt - 7'd1;
                    end
                    ST_DIV_FIX: r_result <= w_fix_res;
                    default: ;
                endcase
            end
        end
    end

    assign ok_to_proceed = flush || (r_state == ST_DONE) || ((r_state == ST_IDLE) && !req_valid);
    assign busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign result        = r_result;

endmodule
`default_nettype wire
